plot_sink: RTL and testbench

- Consumer end of the pixel-plot interface driven by fillscreen, circle and other drawing engines: vga_x/vga_y/vga_colour/vga_plot.
- Range-checks each plot request and converts (x,y) to a linear framebuffer address.
- Buffers accepted writes in a small FIFO and commits them to a single-port 160x120x3 synchronous RAM.
- Gives a scan-out/checker read port priority access to the same RAM port.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/plot_sink_if.sv | 26 ++
 rtl/plot_fifo.sv | 46 ++++
 rtl/plot_sink.sv | 143 ++++++++++++++
 tb/tb_plot_sink.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared screen geometry, framebuffer word type and coordinate-to-address helper
// for the pixel-plot sink.
package vga_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned FB_WORDS = SCREEN_W * SCREEN_H;   // 19200

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  colour;
  } pix_t;

  // y*160 + x as two shifts and adds; 15 bits holds even 127*160+255.
  function automatic logic [14:0] xy_to_addr(input logic [7:0] x, input logic [6:0] y);
    logic [14:0] yy;
    yy = {8'd0, y};
    return (yy << 7) + (yy << 5) + {7'd0, x};
  endfunction

endpackage

// File: rtl/plot_sink_if.sv
// Plot bus from the drawing engines plus the scan-out/checker read port.
interface plot_sink_if;

  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  logic       rd_req;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic       rd_ready;
  logic       rd_valid;
  logic [2:0] rd_colour;

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, rd_req, rd_x, rd_y,
    input  rd_ready, rd_valid, rd_colour
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, rd_req, rd_x, rd_y,
    output rd_ready, rd_valid, rd_colour
  );

endinterface

// File: rtl/plot_fifo.sv
// Small synchronous write-buffer FIFO of pix_t. Pointers carry an extra wrap
// bit so full and empty are told apart without a separate counter.
module plot_fifo
  import vga_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  pix_t        wdata,
  output pix_t        rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  pix_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer advance; the caller guarantees pop only when non-empty and push
  // only when a slot is free (or being freed by a same-cycle pop).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage, no reset needed since empty gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/plot_sink.sv
// Consumer end of the pixel-plot bus: capture, range check, buffer, and commit
// to a single-port framebuffer RAM shared with a higher-priority read port.
module plot_sink #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SCREEN_W   = vga_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H   = vga_pkg::SCREEN_H
) (
  input  logic          clk,
  input  logic          rst_n,
  plot_sink_if.slave    bus,
  output logic [14:0]   fb_addr,
  output logic [2:0]    fb_wdata,
  output logic          fb_we,
  output logic          fb_re,
  input  logic [2:0]    fb_rdata,
  input  logic          clear,
  output logic [14:0]   pixel_count,
  output logic [7:0]    oob_count,
  output logic          overflow,
  output logic          busy
);
  import vga_pkg::*;

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  // capture stage
  logic        cap_vld;
  logic        cap_in_range;
  logic [14:0] cap_addr;
  logic [2:0]  cap_colour;
  logic        plot_in_range;

  // FIFO
  pix_t        fifo_wdata;
  pix_t        head;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        push;
  logic        pop;

  // arbiter / read port
  logic        ready_en;
  logic        rd_ready_int;
  logic        rd_grant;
  logic        rd_in_range;
  logic        drop_full;
  logic        drop_oob;
  logic        rd_valid_q;
  logic        rd_oob_q;

  assign plot_in_range = (32'(bus.vga_x) < SCREEN_W) && (32'(bus.vga_y) < SCREEN_H);
  assign rd_in_range   = (32'(bus.rd_x)  < SCREEN_W) && (32'(bus.rd_y)  < SCREEN_H);

  // Stage C: register the plot with its range verdict and linear address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_vld      <= 1'b0;
      cap_in_range <= 1'b0;
      cap_addr     <= '0;
      cap_colour   <= '0;
    end else begin
      cap_vld <= bus.vga_plot;
      if (bus.vga_plot) begin
        cap_in_range <= plot_in_range;
        cap_addr     <= xy_to_addr(bus.vga_x, bus.vga_y);
        cap_colour   <= bus.vga_colour;
      end
    end
  end

  // Read port opens one cycle after reset is released.
  always_ff @(posedge clk) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Port arbiter and stage F push decision. Reads win the RAM port but are
  // held off once the FIFO is nearly full, so writes always make progress.
  always_comb begin
    rd_ready_int = ready_en && rst_n && (count < (AW+1)'(FIFO_DEPTH - 1));
    rd_grant     = bus.rd_req && rd_ready_int;
    pop          = !rd_grant && !empty;
    push         = cap_vld && cap_in_range && (!full || pop);
    drop_full    = cap_vld && cap_in_range && full && !pop;
    drop_oob     = cap_vld && !cap_in_range;
    fb_re        = rd_grant && rd_in_range;
    fb_we        = pop;
    fb_addr      = '0;
    fb_wdata     = '0;
    if (fb_re) begin
      fb_addr = xy_to_addr(bus.rd_x, bus.rd_y);
    end else if (pop) begin
      fb_addr  = head.addr;
      fb_wdata = head.colour;
    end
  end

  assign fifo_wdata = '{addr: cap_addr, colour: cap_colour};

  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Read return: one cycle after the grant; out-of-range reads return 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_grant;
      rd_oob_q   <= !rd_in_range;
    end
  end

  assign bus.rd_ready  = rd_ready_int;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_colour = (rd_valid_q && !rd_oob_q) ? fb_rdata : 3'd0;

  // Saturating statistics; clear takes priority over any same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pixel_count <= '0;
      oob_count   <= '0;
      overflow    <= 1'b0;
    end else begin
      if (pop && (pixel_count != '1))    pixel_count <= pixel_count + 15'd1;
      if (drop_oob && (oob_count != '1)) oob_count   <= oob_count + 8'd1;
      if (drop_full)                     overflow    <= 1'b1;
    end
  end

  assign busy = !empty || cap_vld;

endmodule

// File: tb/tb_plot_sink.sv
// Directed bench for plot_sink with a behavioural single-port framebuffer RAM.
module tb_plot_sink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] fb_addr;
  logic [2:0]  fb_wdata;
  logic        fb_we;
  logic        fb_re;
  logic [2:0]  fb_rdata = 3'd0;
  logic        clear = 1'b0;
  logic [14:0] pixel_count;
  logic [7:0]  oob_count;
  logic        overflow;
  logic        busy;

  plot_sink_if bus ();

  plot_sink #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .fb_addr     (fb_addr),
    .fb_wdata    (fb_wdata),
    .fb_we       (fb_we),
    .fb_re       (fb_re),
    .fb_rdata    (fb_rdata),
    .clear       (clear),
    .pixel_count (pixel_count),
    .oob_count   (oob_count),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Framebuffer RAM plus write bookkeeping.
  logic [2:0] mem [19200];
  int         hits [19200];
  int         we_cnt = 0;

  always @(posedge clk) begin
    if (fb_re && fb_addr < 15'd19200) fb_rdata <= mem[fb_addr];
    if (fb_we) begin
      we_cnt <= we_cnt + 1;
      if (fb_addr < 15'd19200) begin
        mem[fb_addr]  <= fb_wdata;
        hits[fb_addr] <= hits[fb_addr] + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      nxt();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int  we_snap;
  int  bad;
  logic       prev_grant;
  logic [2:0] prev_exp;

  initial begin
    bus.vga_x = '0; bus.vga_y = '0; bus.vga_colour = '0; bus.vga_plot = 1'b0;
    bus.rd_req = 1'b0; bus.rd_x = '0; bus.rd_y = '0;

    // reset state
    nxt(); nxt();
    chk("rst_pixel_count", pixel_count, 0);
    chk("rst_oob_count", oob_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_rd_ready", bus.rd_ready, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    rst_n = 1'b1;
    nxt();
    chk("post_rst_rd_ready", bus.rd_ready, 1);

    // single plot (5,3) colour 5 -> address 485, fb_we two cycles later
    bus.vga_x = 8'd5; bus.vga_y = 7'd3; bus.vga_colour = 3'b101; bus.vga_plot = 1'b1;
    #1 chk("single_n_we", fb_we, 0);
    nxt();
    bus.vga_plot = 1'b0;
    chk("single_n1_we", fb_we, 0);
    chk("single_n1_busy", busy, 1);
    nxt();
    chk("single_n2_we", fb_we, 1);
    chk("single_n2_addr", fb_addr, 485);
    chk("single_n2_wdata", fb_wdata, 5);
    nxt();
    chk("single_pixel_count", pixel_count, 1);
    chk("single_busy", busy, 0);

    // out-of-range plots
    we_snap = we_cnt;
    bus.vga_plot = 1'b1;
    bus.vga_x = 8'd160; bus.vga_y = 7'd0;   nxt();
    bus.vga_x = 8'd0;   bus.vga_y = 7'd120; nxt();
    bus.vga_x = 8'd255; bus.vga_y = 7'd127; nxt();
    bus.vga_plot = 1'b0;
    nxt(); nxt(); nxt();
    chk("oob_no_we", we_cnt, we_snap);
    chk("oob_count", oob_count, 3);
    chk("oob_busy", busy, 0);

    // clear zeroes counters
    clear = 1'b1;
    nxt();
    clear = 1'b0;
    chk("clear_pixel_count", pixel_count, 0);
    chk("clear_oob_count", oob_count, 0);

    // full raster sweep, 1 plot/cycle, colour (x+y)&7
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        bus.vga_x = 8'(x); bus.vga_y = 7'(y); bus.vga_colour = 3'(x + y); bus.vga_plot = 1'b1;
        nxt();
      end
    end
    bus.vga_plot = 1'b0;
    chk("sweep_busy_n1", busy, 1);
    nxt();
    chk("sweep_busy_n2", busy, 1);
    chk("sweep_last_addr", fb_addr, 19199);
    nxt();
    chk("sweep_busy_n3", busy, 0);
    chk("sweep_pixel_count", pixel_count, 19200);
    chk("sweep_overflow", overflow, 0);
    bad = 0;
    for (int a = 0; a < 19200; a++) begin
      if (hits[a] != ((a == 485) ? 2 : 1)) bad++;
      if (mem[a] !== 3'((a % 160) + (a / 160))) bad++;
    end
    chk("sweep_hits_and_data", bad, 0);

    // write colour 2 at (0,119), then read it back once idle
    bus.vga_x = 8'd0; bus.vga_y = 7'd119; bus.vga_colour = 3'd2; bus.vga_plot = 1'b1;
    nxt();
    bus.vga_plot = 1'b0;
    wait_idle("wr_0_119_idle");
    bus.rd_req = 1'b1; bus.rd_x = 8'd0; bus.rd_y = 7'd119;
    #1;
    chk("rd_ready_idle", bus.rd_ready, 1);
    chk("rd_fb_re", fb_re, 1);
    chk("rd_fb_addr", fb_addr, 19040);
    nxt();
    bus.rd_req = 1'b0;
    chk("rd_valid", bus.rd_valid, 1);
    chk("rd_colour", bus.rd_colour, 2);

    // out-of-range read
    bus.rd_req = 1'b1; bus.rd_x = 8'd200; bus.rd_y = 7'd10;
    #1 chk("rd_oob_no_re", fb_re, 0);
    nxt();
    bus.rd_req = 1'b0;
    chk("rd_oob_valid", bus.rd_valid, 1);
    chk("rd_oob_colour", bus.rd_colour, 0);
    nxt();
    chk("rd_valid_pulse", bus.rd_valid, 0);

    // continuous plots into row 1 with reads of row 50 held high
    prev_grant = 1'b0;
    prev_exp   = 3'd0;
    for (int i = 0; i < 12; i++) begin
      bus.vga_x = 8'(i); bus.vga_y = 7'd1; bus.vga_colour = 3'(i); bus.vga_plot = 1'b1;
      bus.rd_req = 1'b1; bus.rd_x = 8'(i); bus.rd_y = 7'd50;
      #1;
      chk("cont_rd_ready", bus.rd_ready, (i < 4) ? 1 : 0);
      chk("cont_rd_valid", bus.rd_valid, prev_grant);
      if (prev_grant) chk("cont_rd_colour", bus.rd_colour, prev_exp);
      prev_grant = bus.rd_ready;
      prev_exp   = 3'(i + 50);
      nxt();
    end
    bus.vga_plot = 1'b0;
    bus.rd_req   = 1'b0;
    wait_idle("cont_idle");
    chk("cont_pixel_count", pixel_count, 19213);
    chk("cont_overflow", overflow, 0);
    chk("cont_mem_row1", mem[165], 5);

    // build up 3 pending entries, then reset mid-operation
    for (int i = 0; i < 5; i++) begin
      bus.vga_x = 8'(i + 10); bus.vga_y = 7'd2; bus.vga_colour = 3'd1; bus.vga_plot = 1'b1;
      bus.rd_req = 1'b1; bus.rd_x = 8'd0; bus.rd_y = 7'd0;
      nxt();
    end
    bus.vga_plot = 1'b0;
    bus.rd_req   = 1'b0;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    nxt();
    we_snap = we_cnt;
    chk("mid_rst_pixel_count", pixel_count, 0);
    chk("mid_rst_oob_count", oob_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fb_we", fb_we, 0);
    chk("mid_rst_rd_ready", bus.rd_ready, 0);
    rst_n = 1'b1;
    nxt();
    chk("mid_rst_rd_ready_after", bus.rd_ready, 1);
    nxt(); nxt(); nxt(); nxt();
    chk("mid_rst_no_we", we_cnt, we_snap);

    // clear coinciding with a commit
    bus.vga_x = 8'd7; bus.vga_y = 7'd7; bus.vga_colour = 3'd3; bus.vga_plot = 1'b1;
    nxt();
    bus.vga_plot = 1'b0;
    nxt();
    chk("clr_commit_we", fb_we, 1);
    clear = 1'b1;
    nxt();
    clear = 1'b0;
    chk("clr_commit_pixel_count", pixel_count, 0);
    nxt();
    chk("clr_commit_pixel_count_hold", pixel_count, 0);
    chk("clr_commit_busy", busy, 0);
    chk("clr_commit_mem", mem[1127], 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
